// File: rtl/clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_gen
// Description : Master-clock divider bank plus speed-select switch cleaner.
//               Four independent dividers produce registered divided clocks
//               (MHz2, MHz1, KHz31, Hz250) with one-cycle period-start ticks.
//               The raw speed switches pass through a two-flop synchronizer
//               and, optionally, a millisecond-sampled debouncer.
// Ports       : clock      - master clock (50 MHz nominal)
//               n_reset    - asynchronous active-low reset
//               sw_in[1:0] - raw speed-select switches (asynchronous)
//               MHz2/MHz1/KHz31/Hz250         - divided clocks
//               tick2m/tick1m/tick31k/tick250 - period-start strobes
//               sw[1:0]    - cleaned speed select
//               sw_changed - one-cycle strobe when sw takes a new value
// Config      : define SW_DEBOUNCE_EN to insert the switch debouncer;
//               otherwise sw follows the synchronizer output directly.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_gen #(
  parameter int DIV_2M   = 25,
  parameter int DIV_1M   = 50,
  parameter int DIV_31K  = 1600,
  parameter int DIV_250  = 200000,
  parameter int DB_TICK  = 50000,
  parameter int DB_COUNT = 8
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [1:0] sw_in,
  output logic       MHz2,
  output logic       MHz1,
  output logic       KHz31,
  output logic       Hz250,
  output logic       tick2m,
  output logic       tick1m,
  output logic       tick31k,
  output logic       tick250,
  output logic [1:0] sw,
  output logic       sw_changed
);

  localparam int c_NDIV = 4;

  logic [c_NDIV-1:0] w_clk_out;
  logic [c_NDIV-1:0] w_tick_out;

  // --------------------------------------------------------------------------
  // Dividers: output goes high on the wrap DIV-1 -> 0 and low on the edge the
  // counter reaches DIV/2, so odd divisors spend the extra cycle low.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < c_NDIV; gi++) begin : g_div
      localparam int c_DIV = (gi == 0) ? DIV_2M  :
                             (gi == 1) ? DIV_1M  :
                             (gi == 2) ? DIV_31K : DIV_250;
      localparam int c_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
      localparam logic [c_W-1:0] c_LAST    = c_W'(c_DIV - 1);
      localparam logic [c_W-1:0] c_HALF_M1 = c_W'(c_DIV / 2 - 1);
      localparam logic [c_W-1:0] c_ONE     = c_W'(1);

      logic [c_W-1:0] r_cnt;
      logic           r_clk;
      logic           r_tick;

      always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          // Tick is loaded on the same edge that raises the clock output.
          r_tick <= (r_cnt == c_LAST);
          if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            r_clk <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
            if (r_cnt == c_HALF_M1) begin
              r_clk <= 1'b0;
            end
          end
        end
      end

      assign w_clk_out[gi]  = r_clk;
      assign w_tick_out[gi] = r_tick;
    end
  endgenerate

  assign MHz2    = w_clk_out[0];
  assign MHz1    = w_clk_out[1];
  assign KHz31   = w_clk_out[2];
  assign Hz250   = w_clk_out[3];
  assign tick2m  = w_tick_out[0];
  assign tick1m  = w_tick_out[1];
  assign tick31k = w_tick_out[2];
  assign tick250 = w_tick_out[3];

  // --------------------------------------------------------------------------
  // Switch synchronizer (r_sync2 is the synchronized sw_s)
  // --------------------------------------------------------------------------
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_sw_prev;
  logic [1:0] w_sw;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  // --------------------------------------------------------------------------
  // Debouncer: sample sw_s every DB_TICK cycles. The stable counter holds
  // (times the candidate has been seen - 1), so sw loads the candidate on the
  // sample where that count reaches DB_COUNT-1. Saturation keeps reloading
  // the same value, which the change detector ignores.
  // --------------------------------------------------------------------------
  localparam int c_TW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
  localparam int c_SW = $clog2(DB_COUNT) + 1;
  localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(DB_TICK - 1);
  localparam logic [c_TW-1:0] c_TICK_ONE   = c_TW'(1);
  localparam logic [c_SW-1:0] c_STABLE_MAX = c_SW'(DB_COUNT - 1);
  localparam logic [c_SW-1:0] c_STABLE_ONE = c_SW'(1);

  logic [c_TW-1:0] r_db_cnt;
  logic [1:0]      r_cand;
  logic [c_SW-1:0] r_stable;
  logic [1:0]      r_sw_db;
  logic            w_sample;
  logic [1:0]      w_cand_nxt;
  logic [c_SW-1:0] w_stable_nxt;

  assign w_sample = (r_db_cnt == c_TICK_LAST);

  always_comb begin
    w_cand_nxt   = r_cand;
    w_stable_nxt = r_stable;
    if (r_sync2 != r_cand) begin
      w_cand_nxt   = r_sync2;
      w_stable_nxt = '0;
    end else if (r_stable != c_STABLE_MAX) begin
      w_stable_nxt = r_stable + c_STABLE_ONE;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_db_cnt <= '0;
      r_cand   <= 2'b00;
      r_stable <= '0;
      r_sw_db  <= 2'b00;
    end else begin
      r_db_cnt <= w_sample ? '0 : (r_db_cnt + c_TICK_ONE);
      if (w_sample) begin
        r_cand   <= w_cand_nxt;
        r_stable <= w_stable_nxt;
        if (w_stable_nxt == c_STABLE_MAX) begin
          r_sw_db <= w_cand_nxt;
        end
      end
    end
  end

  assign w_sw = r_sw_db;
`else
  // Without the debouncer the DB_* parameters have no effect.
  if (DB_TICK < 1 || DB_COUNT < 1) begin : g_db_unused
  end

  assign w_sw = r_sync2;
`endif

  // --------------------------------------------------------------------------
  // Change detector: compares against last cycle's value so an equal rewrite
  // never strobes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sw_prev <= 2'b00;
    end else begin
      r_sw_prev <= w_sw;
    end
  end

  assign sw         = w_sw;
  assign sw_changed = (w_sw != r_sw_prev);

endmodule
`default_nettype wire

// File: tb/tb_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_gen
// Description : Self-checking bench for clock_gen. Divider outputs are checked
//               against a table of hand-computed values at chosen edges after
//               reset release, then duty/tick counts over a 400-cycle window,
//               the switch path, and an asynchronous mid-period reset.
//               Builds with or without SW_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_gen;

  localparam int c_DB_TICK = 10;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [1:0] sw_in = 2'b00;
  logic       MHz2, MHz1, KHz31, Hz250;
  logic       tick2m, tick1m, tick31k, tick250;
  logic [1:0] sw;
  logic       sw_changed;

  clock_gen #(
    .DIV_2M  (25),
    .DIV_1M  (50),
    .DIV_31K (40),
    .DIV_250 (100),
    .DB_TICK (c_DB_TICK),
    .DB_COUNT(8)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .sw_in     (sw_in),
    .MHz2      (MHz2),
    .MHz1      (MHz1),
    .KHz31     (KHz31),
    .Hz250     (Hz250),
    .tick2m    (tick2m),
    .tick1m    (tick1m),
    .tick31k   (tick31k),
    .tick250   (tick250),
    .sw        (sw),
    .sw_changed(sw_changed)
  );

  always #5 clock = ~clock;

  logic [7:0] w_clkvec;
  assign w_clkvec = {MHz2, tick2m, MHz1, tick1m, KHz31, tick31k, Hz250, tick250};

  int checks  = 0;
  int errors  = 0;
  int edge_no = 0;

  typedef struct {
    int         edge_n;
    logic [7:0] exp;   // {MHz2,tick2m,MHz1,tick1m,KHz31,tick31k,Hz250,tick250}
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge for sampling.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clock);
      edge_no++;
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi2, hi1, hi31, hi250, tk2, tk1, tk31, tk250, rise_err;
    logic [3:0] prev_clk;
    int found;

    vecs[0]  = '{0,   8'b0000_0000};
    vecs[1]  = '{12,  8'b0000_0000};
    vecs[2]  = '{24,  8'b0000_0000};
    vecs[3]  = '{25,  8'b1100_0000};
    vecs[4]  = '{26,  8'b1000_0000};
    vecs[5]  = '{36,  8'b1000_0000};
    vecs[6]  = '{37,  8'b0000_0000};
    vecs[7]  = '{40,  8'b0000_1100};
    vecs[8]  = '{49,  8'b0000_1000};
    vecs[9]  = '{50,  8'b1111_1000};
    vecs[10] = '{59,  8'b1010_1000};
    vecs[11] = '{60,  8'b1010_0000};
    vecs[12] = '{74,  8'b0010_0000};
    vecs[13] = '{75,  8'b1100_0000};
    vecs[14] = '{100, 8'b1111_0011};
    vecs[15] = '{149, 8'b0000_0010};
    vecs[16] = '{150, 8'b1111_0000};
    vecs[17] = '{200, 8'b1111_1111};

    // ---------------- Reset state ----------------
    adv(3);
    chk("reset_clocks", {24'd0, w_clkvec}, 32'd0);
    chk("reset_sw", {29'd0, sw, sw_changed}, 32'd0);

    // Release between edges; edge_no counts edges after release.
    #2;
    n_reset = 1'b1;
    edge_no = 0;

    // ---------------- Table-driven divider vectors ----------------
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].edge_n > edge_no) adv(vecs[i].edge_n - edge_no);
      chk($sformatf("div_vec@%0d", vecs[i].edge_n), {24'd0, w_clkvec}, {24'd0, vecs[i].exp});
    end

    // ---------------- 400-cycle steady-state window ----------------
    hi2 = 0; hi1 = 0; hi31 = 0; hi250 = 0;
    tk2 = 0; tk1 = 0; tk31 = 0; tk250 = 0; rise_err = 0;
    prev_clk = {MHz2, MHz1, KHz31, Hz250};
    for (int i = 0; i < 400; i++) begin
      adv(1);
      hi2 += int'(MHz2);   hi1 += int'(MHz1);
      hi31 += int'(KHz31); hi250 += int'(Hz250);
      tk2 += int'(tick2m); tk1 += int'(tick1m);
      tk31 += int'(tick31k); tk250 += int'(tick250);
      if (tick2m  !== (MHz2  & ~prev_clk[3])) rise_err++;
      if (tick1m  !== (MHz1  & ~prev_clk[2])) rise_err++;
      if (tick31k !== (KHz31 & ~prev_clk[1])) rise_err++;
      if (tick250 !== (Hz250 & ~prev_clk[0])) rise_err++;
      prev_clk = {MHz2, MHz1, KHz31, Hz250};
    end
    chk("mhz2_high_cycles", hi2, 192);
    chk("mhz2_ticks", tk2, 16);
    chk("mhz1_high_cycles", hi1, 200);
    chk("mhz1_ticks", tk1, 8);
    chk("khz31_high_cycles", hi31, 200);
    chk("khz31_ticks", tk31, 10);
    chk("hz250_high_cycles", hi250, 200);
    chk("hz250_ticks", tk250, 4);
    chk("tick_on_rise_errors", rise_err, 0);

`ifndef SW_DEBOUNCE_EN
    // ---------------- Switch path, no debounce ----------------
    sw_in = 2'b10;
    chk("sw_same_cycle", {30'd0, sw}, 32'd0);
    adv(1);
    chk("sw_after_1", {30'd0, sw, sw_changed}, {29'd0, 2'b00, 1'b0});
    adv(1);
    chk("sw_after_2", {30'd0, sw, sw_changed}, {29'd0, 2'b10, 1'b1});
    adv(1);
    chk("sw_after_3", {30'd0, sw, sw_changed}, {29'd0, 2'b10, 1'b0});
    found = 0;
    sw_in = 2'b10;
    for (int i = 0; i < 6; i++) begin
      adv(1);
      if (sw_changed !== 1'b0 || sw !== 2'b10) found++;
    end
    chk("sw_equal_rewrite_no_pulse", found, 0);
    sw_in = 2'b11;
    adv(2);
    chk("sw_to_11", {30'd0, sw, sw_changed}, {29'd0, 2'b11, 1'b1});
`else
    // ---------------- Debounce: short bounces rejected ----------------
    found = 0;
    tk2 = 0;
    for (int k = 0; k < 10; k++) begin
      sw_in = (k % 2 == 0) ? 2'b01 : 2'b00;
      for (int i = 0; i < 3 * c_DB_TICK; i++) begin
        adv(1);
        if (sw !== 2'b00) found++;
        if (sw_changed) tk2++;
      end
    end
    sw_in = 2'b00;
    for (int i = 0; i < 3 * c_DB_TICK; i++) begin
      adv(1);
      if (sw !== 2'b00) found++;
      if (sw_changed) tk2++;
    end
    chk("db_bounce_sw_held", found, 0);
    chk("db_bounce_no_pulse", tk2, 0);

    // ---------------- Debounce: steady change accepted ----------------
    sw_in = 2'b11;
    found = -1;
    tk2 = 0;
    for (int i = 1; i <= 12 * c_DB_TICK; i++) begin
      adv(1);
      if (sw_changed) tk2++;
      if (found < 0 && sw === 2'b11) found = i;
    end
    chk("db_latency_in_window",
        {31'd0, (found >= 7 * c_DB_TICK + 3 && found <= 8 * c_DB_TICK + 2)}, 32'd1);
    chk("db_single_pulse", tk2, 1);
    chk("db_sw_final", {30'd0, sw}, {30'd0, 2'b11});
`endif

    // ---------------- Asynchronous mid-period reset ----------------
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      adv(1);
      if (tick2m) found = 1;
    end
    chk("mhz2_rise_seen_before_reset", found, 1);
    adv(5);
    chk("mhz2_high_mid_period", {31'd0, MHz2}, 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_reset_clocks", {24'd0, w_clkvec}, 32'd0);
    chk("async_reset_sw", {29'd0, sw, sw_changed}, 32'd0);
    adv(3);
    chk("held_reset_clocks", {24'd0, w_clkvec}, 32'd0);
    chk("held_reset_sw", {29'd0, sw, sw_changed}, 32'd0);
    #2;
    n_reset = 1'b1;
    edge_no = 0;
    adv(1);
    chk("post_reset_sw_e1", {30'd0, sw}, 32'd0);
    adv(1);
`ifndef SW_DEBOUNCE_EN
    chk("post_reset_sw_e2", {30'd0, sw, sw_changed}, {29'd0, 2'b11, 1'b1});
`else
    chk("post_reset_sw_e2", {30'd0, sw, sw_changed}, 32'd0);
`endif
    adv(24 - edge_no);
    chk("post_reset_mhz2_e24", {30'd0, MHz2, tick2m}, 32'd0);
    adv(1);
    chk("post_reset_mhz2_e25", {30'd0, MHz2, tick2m}, {30'd0, 2'b11});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
